// File: rtl/hash_req_arbiter_pkg.sv
// Shared types and helpers for the hash engine request arbiter.
// Holds the FSM state encoding, CLOG2 and packed-bus slicing macros.
`ifndef HASH_REQ_ARBITER_PKG_SV
`define HASH_REQ_ARBITER_PKG_SV

`define CLOG2(x) $clog2(x)
`define HRA_SLICE(bus, idx, w) bus[int'(idx)*(w) +: (w)]

package hash_req_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ABSORB,
        ST_SQUEEZE,
        ST_FLUSH,
        ST_RELEASE
    } hra_state_t;

    // Index reached by stepping off places past base, wrapping at n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

`endif

// File: rtl/hash_req_arbiter_rr_arbiter.sv
// Combinational round-robin selector for the hash request arbiter.
// Ports: req (request vector), ptr (last winner), gnt (one-hot),
// idx (winner index), valid (any request present).
module rr_arbiter
    import hash_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [REQ_W-1:0]   idx,
    output logic               valid
);

    // Scan from farthest to nearest so the nearest requester after
    // ptr overwrites any earlier hit and wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[rr_wrap(int'(ptr), k, NUM_REQ)]) begin
                gnt = '0;
                gnt[rr_wrap(int'(ptr), k, NUM_REQ)] = 1'b1;
                idx   = REQ_W'(rr_wrap(int'(ptr), k, NUM_REQ));
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_req_arbiter.sv
// Shares one SHAKE engine and its message-RAM port among NUM_REQ requesters.
// Ports: clk/rst; per-requester i_req, lengths, RAM read port and output
// stream (o_grant, o_req_done, o_dout*); engine side o_hash_* / i_hash_*.
module hash_req_arbiter
    import hash_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int IO_WIDTH   = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*IO_WIDTH-1:0]  i_req_in_len,
    input  logic [NUM_REQ*IO_WIDTH-1:0]  i_req_out_len,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic [NUM_REQ-1:0]           o_req_done,
    output logic [ADDR_WIDTH-1:0]        o_req_addr,
    output logic [NUM_REQ-1:0]           o_req_rd_en,
    input  logic [NUM_REQ*IO_WIDTH-1:0]  i_req_rdata,
    output logic [IO_WIDTH-1:0]          o_dout,
    output logic [NUM_REQ-1:0]           o_dout_valid,
    input  logic [NUM_REQ-1:0]           i_dout_ready,
    output logic                         o_hash_start,
    output logic [IO_WIDTH-1:0]          o_hash_in_len,
    output logic [IO_WIDTH-1:0]          o_hash_out_len,
    input  logic [ADDR_WIDTH-1:0]        i_hash_addr,
    input  logic                         i_hash_rd_en,
    output logic [IO_WIDTH-1:0]          o_hash_rdata,
    input  logic [IO_WIDTH-1:0]          i_hash_dout,
    input  logic                         i_hash_dout_valid,
    output logic                         o_hash_dout_ready,
    output logic                         o_hash_force_done,
    input  logic                         i_hash_force_done_ack,
    input  logic                         i_hash_done
);

    localparam int REQ_W   = `CLOG2(NUM_REQ);
    localparam int LEN_LSB = `CLOG2(IO_WIDTH);

    hra_state_t          state;
    logic [REQ_W-1:0]    ptr;
    logic [REQ_W-1:0]    gidx;
    logic [IO_WIDTH-1:0] words_left;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [REQ_W-1:0]    arb_idx;
    logic                arb_valid;

    logic [IO_WIDTH-1:0] sel_in_len;
    logic [IO_WIDTH-1:0] sel_out_len;
    logic [IO_WIDTH-1:0] sel_words;

    logic fwd;
    logic hs;
    logic last_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_rr (
        .req   (i_req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign sel_in_len  = `HRA_SLICE(i_req_in_len, arb_idx, IO_WIDTH);
    assign sel_out_len = `HRA_SLICE(i_req_out_len, arb_idx, IO_WIDTH);

    // Whole words plus one more if any partial-word bits remain.
    assign sel_words = (sel_out_len >> LEN_LSB)
                     + IO_WIDTH'(|sel_out_len[LEN_LSB-1:0]);

    // The output stream is only forwarded while words are still owed,
    // so ready drops the cycle after the final handshake.
    assign fwd = (state == ST_ABSORB || state == ST_SQUEEZE)
              && (words_left != '0);
    assign hs      = fwd && i_hash_dout_valid && i_dout_ready[gidx];
    assign last_hs = hs && (words_left == IO_WIDTH'(1));

    always_comb begin
        o_req_addr        = '0;
        o_req_rd_en       = '0;
        o_hash_rdata      = '0;
        o_dout            = '0;
        o_dout_valid      = '0;
        o_hash_dout_ready = 1'b0;
        if (state == ST_ABSORB) begin
            o_req_addr        = i_hash_addr;
            o_req_rd_en[gidx] = i_hash_rd_en;
            o_hash_rdata      = `HRA_SLICE(i_req_rdata, gidx, IO_WIDTH);
        end
        if (fwd) begin
            o_dout             = i_hash_dout;
            o_dout_valid[gidx] = i_hash_dout_valid;
            o_hash_dout_ready  = i_dout_ready[gidx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            ptr               <= REQ_W'(NUM_REQ - 1);
            gidx              <= '0;
            words_left        <= '0;
            o_grant           <= '0;
            o_req_done        <= '0;
            o_hash_start      <= 1'b0;
            o_hash_force_done <= 1'b0;
            o_hash_in_len     <= '0;
            o_hash_out_len    <= '0;
        end else begin
            o_req_done   <= '0;
            o_hash_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gidx           <= arb_idx;
                        o_grant        <= arb_gnt;
                        o_hash_in_len  <= sel_in_len;
                        o_hash_out_len <= sel_out_len;
                        words_left     <= sel_words;
                        o_hash_start   <= 1'b1;
                        state          <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_ABSORB;
                end
                ST_ABSORB: begin
                    if (hs) begin
                        words_left <= words_left - IO_WIDTH'(1);
                    end
                    if (last_hs || (i_hash_done && words_left == '0)) begin
                        o_hash_force_done <= 1'b1;
                        state             <= ST_FLUSH;
                    end else if (i_hash_done) begin
                        state <= ST_SQUEEZE;
                    end
                end
                ST_SQUEEZE: begin
                    if (hs) begin
                        words_left <= words_left - IO_WIDTH'(1);
                    end
                    if (last_hs) begin
                        o_hash_force_done <= 1'b1;
                        state             <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (i_hash_force_done_ack) begin
                        o_hash_force_done <= 1'b0;
                        o_req_done        <= o_grant;
                        state             <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    ptr     <= gidx;
                    o_grant <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Randomized self-checking bench for hash_req_arbiter.
// Transaction-level reference model with engine and requester models.
module tb_hash_req_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req, rdy;
    logic [N*W-1:0]    in_len, out_len, rdata;
    logic [AW-1:0]     haddr;
    logic              hrd, hvalid, hack, hdone;
    logic [W-1:0]      hdout;

    logic [N-1:0]      o_grant, o_req_done, o_req_rd_en, o_dout_valid;
    logic [AW-1:0]     o_req_addr;
    logic [W-1:0]      o_dout, o_hash_in_len, o_hash_out_len, o_hash_rdata;
    logic              o_hash_start, o_hash_dout_ready, o_hash_force_done;

    hash_req_arbiter #(
        .NUM_REQ(N), .IO_WIDTH(W), .ADDR_WIDTH(AW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_req                 (req),
        .i_req_in_len          (in_len),
        .i_req_out_len         (out_len),
        .o_grant               (o_grant),
        .o_req_done            (o_req_done),
        .o_req_addr            (o_req_addr),
        .o_req_rd_en           (o_req_rd_en),
        .i_req_rdata           (rdata),
        .o_dout                (o_dout),
        .o_dout_valid          (o_dout_valid),
        .i_dout_ready          (rdy),
        .o_hash_start          (o_hash_start),
        .o_hash_in_len         (o_hash_in_len),
        .o_hash_out_len        (o_hash_out_len),
        .i_hash_addr           (haddr),
        .i_hash_rd_en          (hrd),
        .o_hash_rdata          (o_hash_rdata),
        .i_hash_dout           (hdout),
        .i_hash_dout_valid     (hvalid),
        .o_hash_dout_ready     (o_hash_dout_ready),
        .o_hash_force_done     (o_hash_force_done),
        .i_hash_force_done_ack (hack),
        .i_hash_done           (hdone)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    int m_last, g_exp, exp_words, rcv_cnt, starts, cyc;
    int done_cyc, eng_phase, eng_cnt, rdy_mode;
    bit eng_first, eng_hold, pend_at_done, reraise0, grant_clr_pend;
    logic [W-1:0] eng_word;
    int served[$];

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [W-1:0] sl(input logic [N*W-1:0] b, input int i);
        return b[i*W +: W];
    endfunction

    task automatic model_reset();
        m_last = N - 1; g_exp = -1; exp_words = 0; rcv_cnt = 0;
        starts = 0; done_cyc = -1; eng_phase = 0; eng_cnt = 0;
        eng_first = 0; eng_hold = 0; pend_at_done = 0;
        reraise0 = 0; grant_clr_pend = 0;
    endtask

    task automatic step();
        int p;
        bit absorb_chk, fwd;
        @(negedge clk);
        cyc++;
        absorb_chk = 0;
        if (grant_clr_pend) begin
            chk("grant_clr", o_grant, 0);
            grant_clr_pend = 0;
        end
        if (o_hash_start) begin
            p = rr_pick(req, m_last);
            chk("winner_exists", p >= 0, 1);
            if (p < 0) p = 0;
            g_exp = p;
            served.push_back(p);
            chk("grant", o_grant, 1 << p);
            chk("in_len", o_hash_in_len, sl(in_len, p));
            chk("out_len", o_hash_out_len, sl(out_len, p));
            exp_words = (int'(sl(out_len, p)) + W - 1) / W;
            rcv_cnt = 0;
            starts++;
            if (done_cyc >= 0 && pend_at_done) chk("gap", cyc - done_cyc, 2);
            done_cyc = -1;
            eng_phase = 1; eng_first = 1; eng_hold = 0;
            eng_cnt = $urandom_range(0, 3);
        end
        if (o_req_done != 0) begin
            chk("done", o_req_done, (g_exp >= 0) ? (1 << g_exp) : 0);
            chk("words", rcv_cnt, exp_words);
            chk("starts", starts, 1);
            starts = 0;
            if (g_exp >= 0) begin
                m_last = g_exp;
                req[g_exp] = 1'b0;
            end
            if (reraise0 && g_exp == 0) begin
                req[0] = 1'b1;
                reraise0 = 0;
            end
            pend_at_done = (req != 0);
            done_cyc = cyc;
            g_exp = -1;
            grant_clr_pend = 1;
        end
        // engine model
        hdone = 0; hack = 0; hrd = 0; hvalid = 0;
        rdata = {$urandom, $urandom, $urandom, $urandom};
        haddr = AW'($urandom);
        hdout = $urandom;
        if (o_hash_force_done && eng_phase != 3) begin
            eng_phase = 3;
            eng_cnt = $urandom_range(0, 3);
            eng_hold = 0;
        end
        case (eng_phase)
            1: begin
                if (eng_first) eng_first = 0;
                else begin
                    absorb_chk = 1;
                    hrd = 1'($urandom);
                    if (eng_cnt == 0) begin
                        hdone = 1;
                        eng_phase = 2;
                    end else eng_cnt--;
                end
            end
            2: begin
                if (!eng_hold && $urandom_range(0, 3) != 0) begin
                    eng_hold = 1;
                    eng_word = $urandom;
                end
                hvalid = eng_hold;
                if (eng_hold) hdout = eng_word;
            end
            3: begin
                if (eng_cnt == 0) begin
                    hack = 1;
                    eng_phase = 0;
                end else eng_cnt--;
            end
            default: ;
        endcase
        // requester readiness
        rdy = N'($urandom);
        if (rdy_mode != 0) rdy[1] = 1'(cyc % 2);
        #1;
        chk("onehot", $countones(o_grant) <= 1, 1);
        if (absorb_chk) begin
            chk("rd_en", o_req_rd_en, hrd ? (1 << g_exp) : 0);
            chk("addr", o_req_addr, haddr);
            chk("rdata", o_hash_rdata, sl(rdata, g_exp));
        end else begin
            chk("rd_en_off", o_req_rd_en, 0);
        end
        fwd = (g_exp >= 0) && (eng_phase == 2 || absorb_chk)
           && (rcv_cnt < exp_words);
        chk("dvalid", o_dout_valid, (fwd && hvalid) ? (1 << g_exp) : 0);
        chk("hready", o_hash_dout_ready, fwd ? rdy[g_exp] : 1'b0);
        if (fwd && hvalid && rdy[g_exp]) begin
            chk("dout", o_dout, eng_word);
            rcv_cnt++;
            eng_hold = 0;
        end
    endtask

    task automatic run(input int bound);
        int b;
        b = 0;
        do begin
            step();
            b++;
        end while (!(g_exp < 0 && req == 0 && eng_phase == 0) && b < bound);
        if (b >= bound) chk("timeout", 0, 1);
        step();
    endtask

    task automatic do_reset();
        rst = 1; req = 0; hvalid = 0; hack = 0; hdone = 0; hrd = 0;
        @(negedge clk);
        #1;
        chk("rst_outs", {o_grant, o_req_done, o_req_rd_en, o_dout_valid,
                         o_hash_start, o_hash_force_done, o_hash_dout_ready}, 0);
        chk("rst_lens", {o_hash_in_len, o_hash_out_len}, 0);
        rst = 0;
        model_reset();
    endtask

    task automatic setl(input int i, input int il, input int ol);
        in_len[i*W +: W]  = W'(il);
        out_len[i*W +: W] = W'(ol);
    endtask

    initial begin
        int b;
        rst = 1; req = 0; rdy = 0; in_len = 0; out_len = 0; rdata = 0;
        haddr = 0; hrd = 0; hvalid = 0; hack = 0; hdone = 0; hdout = 0;
        cyc = 0; rdy_mode = 0;
        model_reset();
        do_reset();

        // two simultaneous requests, requester 0 re-raises after done
        setl(0, 256, 64);
        setl(2, 512, 96);
        req = 4'b0101;
        reraise0 = 1;
        run(3000);
        chk("order_n", served.size(), 3);
        if (served.size() == 3) begin
            chk("order0", served[0], 0);
            chk("order1", served[1], 2);
            chk("order2", served[2], 0);
        end
        served.delete();

        // single requester, 8 output words
        setl(0, 256, 256);
        req = 4'b0001;
        run(2000);
        chk("t1_n", served.size(), 1);
        served.delete();

        // toggling ready on requester 1
        rdy_mode = 1;
        setl(1, 128, 128);
        req = 4'b0010;
        run(2000);
        rdy_mode = 0;

        // zero-length and partial-word output
        setl(2, 64, 0);
        req = 4'b0100;
        run(2000);
        setl(2, 64, 40);
        req = 4'b0100;
        run(2000);
        served.delete();

        // reset in the middle of the squeeze phase
        setl(0, 256, 256);
        req = 4'b0001;
        b = 0;
        do begin
            step();
            b++;
        end while (rcv_cnt < 2 && b < 500);
        chk("mid_reached", rcv_cnt >= 2, 1);
        do_reset();
        served.delete();
        setl(1, 200, 70);
        setl(3, 300, 100);
        req = 4'b1010;
        run(3000);
        chk("post_rst_n", served.size(), 2);
        if (served.size() == 2) begin
            chk("post_rst0", served[0], 1);
            chk("post_rst1", served[1], 3);
        end

        // random traffic
        repeat (25) begin
            for (int i = 0; i < N; i++)
                setl(i, $urandom_range(0, 1023), $urandom_range(0, 600));
            req = N'($urandom_range(1, 15));
            run(6000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
